writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- MEM/WB pipeline register and writeback-select stage of the RV32I core. Sits directly upstream of the register file and drives its write port (write_enale, writedata_add, write_data).
- Captures one retiring instruction per cycle from the memory stage and selects the result source: ALU result, load data, or PC+4.
- For loads, extracts the byte or halfword from the raw memory word and sign- or zero-extends it. Flags misaligned loads.

Parameters:
DataWidth, 32, datapath width
RegAddress, 5, register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
mem_valid  in  1  memory stage holds a valid instruction
mem_ready  out  1  stage accepts mem_* this cycle; equals !stall
stall  in  1  hazard-unit stall; stage inserts a bubble
flush  in  1  kill the instruction being captured this cycle
mem_reg_write  in  1  instruction writes rd
mem_rd_addr  in  RegAddress  destination register
mem_wb_sel  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved
mem_funct3  in  3  load type
mem_alu_result  in  DataWidth  ALU result / load address
mem_pc4  in  DataWidth  PC+4
mem_load_data  in  DataWidth  raw aligned word from data memory
write_enale  out  1  register-file write enable
writedata_add  out  RegAddress  register-file write address
write_data  out  DataWidth  register-file write data (also the forwarding source)
wb_valid  out  1  valid instruction present in writeback
load_misaligned  out  1  one-cycle pulse: misaligned load retired, write suppressed
instret  out  64  retired-instruction count (optional feature)

Behaviour:
- Capture condition: mem_valid && !stall && !flush. On capture, register rd, reg_write, the selected/extracted data and the misalign flag, and set wb_valid=1. Latency is one cycle from capture to register-file write.
- When not capturing (stall, flush or !mem_valid): wb_valid <= 0 next cycle, creating a bubble. Data registers may hold stale values. flush has priority over stall and mem_valid.
- Data select:
  - 00: mem_alu_result
  - 01: extracted load data
  - 10: mem_pc4
  - 11: zero, with reg_write forced to 0
- Load extraction, offset = mem_alu_result[1:0]:
  - LB (000) / LBU (100): byte at offset*8, sign-/zero-extended.
  - LH (001) / LHU (101): halfword at offset[1]*16, sign-/zero-extended.
  - LW (010): whole word.
  - Any other funct3: data 0, reg_write forced to 0.
- Misaligned load: wb_sel=01 with LH/LHU and offset[0]=1, or LW with offset!=0. Captured with reg_write forced to 0. load_misaligned=1 for exactly the cycle that instruction sits in writeback (wb_valid=1).
- write_enale = wb_valid && reg_write && (rd != 0). Combinational from registers; x0 is never written.
- writedata_add and write_data come directly from the registers.
- Reset (async, rst=0): wb_valid, reg_write, rd, data, load_misaligned and instret all clear to 0, so write_enale=0. Reset mid-stream discards the in-flight instruction. First capture is on the first clk edge after rst deasserts.
- mem_ready is combinational: !stall. It is low during reset only if stall is high.

Optional Feature:
- Macro WB_INSTRET_EN.
- Defined: instret is a 64-bit counter, reset 0. It increments by 1 on every cycle with wb_valid=1, including misaligned and x0 writes, and wraps from 2^64-1 to 0.
- Undefined: no counter logic; instret tied to 0.

Test Plan:
- ALU writeback: mem_valid=1, wb_sel=00, rd=5, alu=0x0000_1234, reg_write=1 -> next cycle write_enale=1, writedata_add=5, write_data=0x0000_1234.
- Loads: load_data=0x80FF_7F01 with LB at offset 3 -> 0xFFFF_FF80. LBU at offset 3 -> 0x0000_0080. LH at offset 2 -> 0xFFFF_80FF. LHU at offset 0 -> 0x0000_7F01.
- Misaligned: LW with alu=0x1002, rd=7 -> wb_valid=1, write_enale=0, load_misaligned=1 for one cycle. Same test with LH at alu=0x1003.
- x0 and PC+4: wb_sel=10, pc4=0x0000_0104, rd=0 -> write_enale=0. Repeat with rd=1 -> write_data=0x0000_0104, write_enale=1.
- Stall/flush: stall=1 with mem_valid=1 -> mem_ready=0, wb_valid=0 next cycle. flush=1 together with stall=1 -> wb_valid=0. Four back-to-back valid instructions with no stall -> four consecutive write cycles.
- Reset/instret: with WB_INSTRET_EN defined, retire 3 instructions and 1 bubble -> instret=3. Assert rst mid-stream -> all outputs 0 immediately, before any clk edge. Without the macro, instret stays 0.

Source files
------------

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and writeback-select stage: load extraction, misalign flagging, register-file write port.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
module writeback_stage #(
  parameter int DataWidth  = 32,
  parameter int RegAddress = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  mem_reg_write,
  input  logic [RegAddress-1:0] mem_rd_addr,
  input  logic [1:0]            mem_wb_sel,
  input  logic [2:0]            mem_funct3,
  input  logic [DataWidth-1:0]  mem_alu_result,
  input  logic [DataWidth-1:0]  mem_pc4,
  input  logic [DataWidth-1:0]  mem_load_data,
  output logic                  write_enale,
  output logic [RegAddress-1:0] writedata_add,
  output logic [DataWidth-1:0]  write_data,
  output logic                  wb_valid,
  output logic                  load_misaligned,
  output logic [63:0]           instret
);

  typedef enum logic [1:0] {
    SEL_ALU  = 2'b00,
    SEL_LOAD = 2'b01,
    SEL_PC4  = 2'b10,
    SEL_NONE = 2'b11
  } wb_sel_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } funct3_e;

  logic                  capture;
  logic [1:0]            offset;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DataWidth-1:0]  load_data;
  logic                  load_ok;
  logic                  load_mis;
  logic [DataWidth-1:0]  next_data;
  logic                  next_write;
  logic                  next_mis;

  logic                  reg_write;
  logic [RegAddress-1:0] rd;
  logic [DataWidth-1:0]  data;

  assign capture   = mem_valid && !stall && !flush;
  assign mem_ready = !stall;

  assign offset   = mem_alu_result[1:0];
  assign byte_sel = mem_load_data[{offset, 3'b000} +: 8];
  assign half_sel = offset[1] ? mem_load_data[31:16] : mem_load_data[15:0];

  always_comb begin
    load_data = '0;
    load_ok   = 1'b1;
    load_mis  = 1'b0;
    case (mem_funct3)
      F3_LB:  load_data = {{(DataWidth-8){byte_sel[7]}}, byte_sel};
      F3_LBU: load_data = {{(DataWidth-8){1'b0}}, byte_sel};
      F3_LH: begin
        load_data = {{(DataWidth-16){half_sel[15]}}, half_sel};
        load_mis  = offset[0];
      end
      F3_LHU: begin
        load_data = {{(DataWidth-16){1'b0}}, half_sel};
        load_mis  = offset[0];
      end
      F3_LW: begin
        load_data = mem_load_data;
        load_mis  = |offset;
      end
      default: load_ok = 1'b0;
    endcase
  end

  always_comb begin
    next_data  = '0;
    next_write = 1'b0;
    next_mis   = 1'b0;
    case (mem_wb_sel)
      SEL_ALU: begin
        next_data  = mem_alu_result;
        next_write = mem_reg_write;
      end
      SEL_LOAD: begin
        next_data  = load_data;
        next_write = mem_reg_write && load_ok && !load_mis;
        next_mis   = load_mis;
      end
      SEL_PC4: begin
        next_data  = mem_pc4;
        next_write = mem_reg_write;
      end
      default: begin
        next_data  = '0;
        next_write = 1'b0;
      end
    endcase
  end

  // Payload registers hold stale values across bubbles; wb_valid gates every use.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid        <= 1'b0;
      reg_write       <= 1'b0;
      rd              <= '0;
      data            <= '0;
      load_misaligned <= 1'b0;
    end else begin
      wb_valid        <= capture;
      load_misaligned <= capture && next_mis;
      if (capture) begin
        reg_write <= next_write;
        rd        <= mem_rd_addr;
        data      <= next_data;
      end
    end
  end

  assign write_enale   = wb_valid && reg_write && (rd != '0);
  assign writedata_add = rd;
  assign write_data    = data;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret_q <= '0;
    end else if (wb_valid) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed vector table, reset/retire sequences, randomized model check.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic        mem_ready;
  logic        stall;
  logic        flush;
  logic        mem_reg_write;
  logic [4:0]  mem_rd_addr;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_pc4;
  logic [31:0] mem_load_data;
  logic        write_enale;
  logic [4:0]  writedata_add;
  logic [31:0] write_data;
  logic        wb_valid;
  logic        load_misaligned;
  logic [63:0] instret;

  writeback_stage #(.DataWidth(32), .RegAddress(5)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .stall(stall), .flush(flush),
    .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_wb_sel(mem_wb_sel),
    .mem_funct3(mem_funct3), .mem_alu_result(mem_alu_result), .mem_pc4(mem_pc4),
    .mem_load_data(mem_load_data),
    .write_enale(write_enale), .writedata_add(writedata_add), .write_data(write_data),
    .wb_valid(wb_valid), .load_misaligned(load_misaligned), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, stall, flush, rw;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [31:0] alu, pc4, ld;
    logic        exp_valid, exp_we, exp_mis;
    logic [31:0] exp_data;
  } vec_t;

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic        cur_valid = 1'b0;
  logic [63:0] exp_instret = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic valid, input logic stall_i, input logic flush_i,
                              input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                              input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4,
                              input logic [31:0] ld, input logic ev, input logic ewe,
                              input logic emis, input logic [31:0] edata);
    vec_t v;
    v.valid = valid; v.stall = stall_i; v.flush = flush_i; v.rw = rw; v.rd = rd;
    v.sel = sel; v.f3 = f3; v.alu = alu; v.pc4 = pc4; v.ld = ld;
    v.exp_valid = ev; v.exp_we = ewe; v.exp_mis = emis; v.exp_data = edata;
    return v;
  endfunction

  // Reference: result computed from the load/select rules with shifts and arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    logic [31:0] b, h, d;
    int unsigned off;
    logic rw, mis;
    off = 32'(v.alu[1:0]);
    rw  = v.rw;
    mis = 1'b0;
    d   = '0;
    b = (v.ld >> (8 * off)) & 32'hFF;
    h = (v.ld >> (16 * (off / 2))) & 32'hFFFF;
    case (v.sel)
      2'd0: d = v.alu;
      2'd2: d = v.pc4;
      2'd3: begin d = '0; rw = 1'b0; end
      default: begin
        case (v.f3)
          3'd0: d = (b >= 128) ? b - 32'd256 : b;
          3'd4: d = b;
          3'd1: begin d = (h >= 32768) ? h - 32'd65536 : h; mis = (off % 2) != 0; end
          3'd5: begin d = h; mis = (off % 2) != 0; end
          3'd2: begin d = v.ld; mis = off != 0; end
          default: begin d = '0; rw = 1'b0; end
        endcase
      end
    endcase
    if (mis) rw = 1'b0;
    r.exp_valid = v.valid && !v.stall && !v.flush;
    r.exp_we    = r.exp_valid && rw && (v.rd != 5'd0);
    r.exp_mis   = r.exp_valid && mis;
    r.exp_data  = d;
    return r;
  endfunction

  function automatic logic [63:0] instret_exp();
`ifdef WB_INSTRET_EN
    return exp_instret;
`else
    return 64'd0;
`endif
  endfunction

  // Called at a negedge: drive, clock once, check at the following negedge.
  task automatic step(input vec_t v, input string name);
    mem_valid = v.valid; stall = v.stall; flush = v.flush; mem_reg_write = v.rw;
    mem_rd_addr = v.rd; mem_wb_sel = v.sel; mem_funct3 = v.f3;
    mem_alu_result = v.alu; mem_pc4 = v.pc4; mem_load_data = v.ld;
    #1;
    chk({name, ".mem_ready"}, 64'(mem_ready), 64'(!v.stall));
    if (cur_valid) exp_instret++;
    @(negedge clk);
    chk({name, ".wb_valid"}, 64'(wb_valid), 64'(v.exp_valid));
    chk({name, ".write_enale"}, 64'(write_enale), 64'(v.exp_we));
    chk({name, ".load_misaligned"}, 64'(load_misaligned), 64'(v.exp_mis));
    chk({name, ".instret"}, instret, instret_exp());
    if (v.exp_valid) chk({name, ".writedata_add"}, 64'(writedata_add), 64'(v.rd));
    if (v.exp_valid && !v.exp_mis) chk({name, ".write_data"}, 64'(write_data), 64'(v.exp_data));
    cur_valid = v.exp_valid;
  endtask

  task automatic check_all_zero(input string name);
    chk({name, ".wb_valid"}, 64'(wb_valid), 64'd0);
    chk({name, ".write_enale"}, 64'(write_enale), 64'd0);
    chk({name, ".writedata_add"}, 64'(writedata_add), 64'd0);
    chk({name, ".write_data"}, 64'(write_data), 64'd0);
    chk({name, ".load_misaligned"}, 64'(load_misaligned), 64'd0);
    chk({name, ".instret"}, instret, 64'd0);
  endtask

  vec_t tbl[16];
  vec_t idle;

  initial begin
    localparam logic [31:0] LD = 32'h80FF_7F01;
    tbl[0]  = mk(1,0,0,1, 5, 2'b00, 3'b000, 32'h0000_1234, 32'h0, LD,  1,1,0, 32'h0000_1234);
    tbl[1]  = mk(1,0,0,1, 2, 2'b01, 3'b000, 32'h0000_1003, 32'h0, LD,  1,1,0, 32'hFFFF_FF80);
    tbl[2]  = mk(1,0,0,1, 2, 2'b01, 3'b100, 32'h0000_1003, 32'h0, LD,  1,1,0, 32'h0000_0080);
    tbl[3]  = mk(1,0,0,1, 3, 2'b01, 3'b001, 32'h0000_1002, 32'h0, LD,  1,1,0, 32'hFFFF_80FF);
    tbl[4]  = mk(1,0,0,1, 3, 2'b01, 3'b101, 32'h0000_1000, 32'h0, LD,  1,1,0, 32'h0000_7F01);
    tbl[5]  = mk(1,0,0,1, 7, 2'b01, 3'b010, 32'h0000_1002, 32'h0, LD,  1,0,1, 32'h0);
    tbl[6]  = mk(1,0,0,1, 7, 2'b01, 3'b001, 32'h0000_1003, 32'h0, LD,  1,0,1, 32'h0);
    tbl[7]  = mk(1,0,0,1, 0, 2'b10, 3'b000, 32'h0, 32'h0000_0104, LD,  1,0,0, 32'h0000_0104);
    tbl[8]  = mk(1,0,0,1, 1, 2'b10, 3'b000, 32'h0, 32'h0000_0104, LD,  1,1,0, 32'h0000_0104);
    tbl[9]  = mk(1,1,0,1, 6, 2'b00, 3'b000, 32'h0000_5555, 32'h0, LD,  0,0,0, 32'h0);
    tbl[10] = mk(1,1,1,1, 6, 2'b00, 3'b000, 32'h0000_5555, 32'h0, LD,  0,0,0, 32'h0);
    tbl[11] = mk(1,0,0,1, 3, 2'b11, 3'b000, 32'hABCD_0000, 32'h4, LD,  1,0,0, 32'h0);
    tbl[12] = mk(1,0,0,1, 4, 2'b01, 3'b011, 32'h0000_1000, 32'h0, LD,  1,0,0, 32'h0);
    tbl[13] = mk(1,0,0,1, 9, 2'b01, 3'b010, 32'h0000_2000, 32'h0, 32'hDEAD_BEEF, 1,1,0, 32'hDEAD_BEEF);
    tbl[14] = mk(1,0,1,1, 9, 2'b00, 3'b000, 32'h0000_7777, 32'h0, LD,  0,0,0, 32'h0);
    tbl[15] = mk(0,0,0,1, 9, 2'b00, 3'b000, 32'h0000_7777, 32'h0, LD,  0,0,0, 32'h0);
    idle    = mk(0,0,0,0, 0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 0,0,0, 32'h0);

    rst = 1'b0; mem_valid = 0; stall = 0; flush = 0; mem_reg_write = 0; mem_rd_addr = '0;
    mem_wb_sel = '0; mem_funct3 = '0; mem_alu_result = '0; mem_pc4 = '0; mem_load_data = '0;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) step(tbl[i], $sformatf("vec%0d", i));

    // Four back-to-back retirements, then a reset pulse between clock edges.
    for (int i = 0; i < 4; i++)
      step(model(mk(1,0,0,1, 5'(10+i), 2'b00, 3'b000, 32'(i*3+1), 32'h0, 32'h0, 0,0,0, 32'h0)),
           $sformatf("b2b%0d", i));
    #2 rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst = 1'b1;
    cur_valid = 1'b0;
    exp_instret = '0;

    for (int i = 0; i < 3; i++)
      step(model(mk(1,0,0,1, 5'(20+i), 2'b10, 3'b000, 32'h0, 32'(100+4*i), 32'h0, 0,0,0, 32'h0)),
           $sformatf("ret%0d", i));
    step(idle, "bubble");
    step(idle, "idle");
`ifdef WB_INSTRET_EN
    chk("instret_after_3", instret, 64'd3);
`else
    chk("instret_tied", instret, 64'd0);
`endif

    for (int n = 0; n < 400; n++) begin
      vec_t v;
      v = idle;
      v.valid = ($urandom_range(0, 3) != 0);
      v.stall = ($urandom_range(0, 3) == 0);
      v.flush = ($urandom_range(0, 7) == 0);
      v.rw    = ($urandom_range(0, 7) != 0);
      v.rd    = 5'($urandom_range(0, 31));
      v.sel   = 2'($urandom_range(0, 3));
      v.f3    = 3'($urandom_range(0, 7));
      v.alu   = $urandom;
      v.pc4   = $urandom;
      v.ld    = $urandom;
      step(model(v), $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
